// File: rtl/fetch_pkg.sv
// Shared constants and the prefetch queue entry layout for the instruction-fetch front end.
package fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;
   localparam int unsigned PC_INC           = 4;
   localparam int unsigned INST_W           = 32;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic              adel;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_if.sv
// Redirect, instruction-memory and decode-side signals of the fetch front end.
interface fetch_prefetch_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_addr_ok;
   logic [DW-1:0] inst_rdata;
   logic          inst_data_ok;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_pc;
   logic [DW-1:0] out_inst;
   logic          out_adel;

   modport master (
      input  redirect_valid, redirect_pc,
      output inst_req, inst_addr,
      input  inst_addr_ok, inst_rdata, inst_data_ok,
      output out_valid,
      input  out_ready,
      output out_pc, out_inst, out_adel
   );

   modport slave (
      output redirect_valid, redirect_pc,
      input  inst_req, inst_addr,
      output inst_addr_ok, inst_rdata, inst_data_ok,
      input  out_valid,
      output out_ready,
      input  out_pc, out_inst, out_adel
   );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO with flush; the head is presented from registers one cycle after push.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 33,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          valid,
   output logic [CW-1:0] count
);
   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          pop_ok;

   assign pop_ok = pop && (count_reg != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)   wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + CW'(push) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr_reg] <= din;
   end

   assign dout  = mem[rd_ptr_reg];
   assign valid = (count_reg != '0);
   assign count = count_reg;
endmodule

// File: rtl/fetch_prefetch.sv
// Fetch front end: PC generation, credit-limited request issue, prefetch queue, redirect flush.
// Define FETCH_ADEL_EN to turn misaligned fetch PCs into queued adel entries instead of aligned fetches.
module fetch_prefetch
   import fetch_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DW       = 32,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT),
   parameter int            DEPTH    = 4
) (
   input  logic             clk,
   input  logic             reset,
   fetch_prefetch_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
`ifdef FETCH_ADEL_EN
   localparam int EW = DW + 1;
`else
   localparam int EW = DW;
`endif

   logic [AW-1:0] fetch_pc_reg, head_pc_reg;
   logic [CW-1:0] outstanding_reg, outstanding_next;
   logic [CW-1:0] drop_reg, drop_next;
   logic [CW-1:0] fifo_count;
   logic          halted;
   logic          misaligned;
   logic          credit_ok, issue_ok, adel_fault;
   logic          accept, push, pop, fifo_valid;
   logic [EW-1:0] push_data, head_data;

   // Credits cover both queued entries and requests still in flight, so the queue never overflows.
   assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding_reg}) < DEPTH_W;
   assign issue_ok   = !reset && credit_ok && !bus.redirect_valid && !halted;
   assign bus.inst_req = issue_ok && !misaligned;
   assign adel_fault = issue_ok && misaligned;
   assign accept     = bus.inst_req && bus.inst_addr_ok;
   assign pop        = fifo_valid && bus.out_ready;

`ifdef FETCH_ADEL_EN
   logic halted_reg;

   assign misaligned    = (fetch_pc_reg[1:0] != 2'b00);
   assign halted        = halted_reg;
   assign bus.inst_addr = fetch_pc_reg;
   assign push_data     = adel_fault ? {{DW{1'b0}}, 1'b1} : {bus.inst_rdata, 1'b0};
   assign bus.out_inst  = head_data[EW-1:1];
   assign bus.out_adel  = head_data[0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   halted_reg <= 1'b0;
      else if (bus.redirect_valid) halted_reg <= 1'b0;
      else if (adel_fault)         halted_reg <= 1'b1;
   end
`else
   assign misaligned    = 1'b0;
   assign halted        = 1'b0;
   assign bus.inst_addr = {fetch_pc_reg[AW-1:2], 2'b00};
   assign push_data     = bus.inst_rdata;
   assign bus.out_inst  = head_data;
   assign bus.out_adel  = 1'b0;
`endif

   always_comb begin
      outstanding_next = outstanding_reg + CW'(accept) - CW'(bus.inst_data_ok);
      drop_next        = drop_reg;
      push             = adel_fault;
      if (bus.redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old stream.
         drop_next = outstanding_next;
      end else if (bus.inst_data_ok) begin
         if (drop_reg != '0) drop_next = drop_reg - 1'b1;
         else                push      = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_reg    <= RESET_PC;
         head_pc_reg     <= RESET_PC;
         outstanding_reg <= '0;
         drop_reg        <= '0;
      end else begin
         outstanding_reg <= outstanding_next;
         drop_reg        <= drop_next;
         if (bus.redirect_valid) begin
            fetch_pc_reg <= bus.redirect_pc;
            head_pc_reg  <= bus.redirect_pc;
         end else begin
            if (accept) fetch_pc_reg <= fetch_pc_reg + AW'(PC_INC);
            if (pop)    head_pc_reg  <= head_pc_reg + AW'(PC_INC);
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH),
      .DW    (EW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bus.redirect_valid),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (head_data),
      .valid (fifo_valid),
      .count (fifo_count)
   );

   assign bus.out_valid = fifo_valid;
   assign bus.out_pc    = head_pc_reg;
endmodule
